// File: rtl/epp_pkg.sv
// Shared definitions for the EPP host initiator: command encodings, FSM states
// and default timing constants.
package epp_pkg;

    typedef enum logic [1:0] {
        OP_AWR = 2'd0,
        OP_DWR = 2'd1,
        OP_ARD = 2'd2,
        OP_DRD = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 1024;

endpackage

// File: rtl/epp_host_if.sv
// Command/response handshake between a requester and the EPP host.
interface epp_host_if;
    import epp_pkg::*;

    logic       req_valid;
    logic       req_ready;
    op_t        req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/epp_sync.sv
// Two-flop synchronizer for the asynchronous EppWait handshake.
module epp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/epp_host.sv
// EPP host initiator: one command in, one full address/data cycle on the pins, one response out.
// Optional abort on a stuck peripheral when EPP_HOST_TIMEOUT_EN is defined.
module epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    epp_host_if.slave  req_if,
    output logic       EppAstb,
    output logic       EppDstb,
    output logic       EppWR,
    input  logic       EppWait,
    inout  wire  [7:0] EppDB
);

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rd_q, rd_d;
    logic [15:0] setup_cnt_q, setup_cnt_d;
    logic        astb_q, astb_d;
    logic        dstb_q, dstb_d;
    logic        wr_q, wr_d;
    logic        db_oe_q, db_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        wait_s;

`ifdef EPP_HOST_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        rsp_err_q, rsp_err_d;
`else
    logic        unused_tmo;
    assign unused_tmo = (TIMEOUT > 0);
`endif

    epp_sync u_wait_sync (
        .clk (clk),
        .rst (rst),
        .d_i (EppWait),
        .q_o (wait_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AWR;
            data_q      <= 8'h00;
            rd_q        <= 8'h00;
            setup_cnt_q <= 16'd0;
            astb_q      <= 1'b1;
            dstb_q      <= 1'b1;
            wr_q        <= 1'b1;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
`ifdef EPP_HOST_TIMEOUT_EN
            tmo_q       <= 16'd0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            setup_cnt_q <= setup_cnt_d;
            astb_q      <= astb_d;
            dstb_q      <= dstb_d;
            wr_q        <= wr_d;
            db_oe_q     <= db_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef EPP_HOST_TIMEOUT_EN
            tmo_q       <= tmo_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Pin outputs are registered from next-state values so strobes never glitch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        rd_d        = rd_q;
        setup_cnt_d = setup_cnt_q;
        astb_d      = astb_q;
        dstb_d      = dstb_q;
        wr_d        = wr_q;
        db_oe_d     = db_oe_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
        tmo_d       = tmo_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    op_d        = req_if.req_op;
                    data_d      = req_if.req_data;
                    wr_d        = req_if.req_op[1];
                    db_oe_d     = ~req_if.req_op[1];
                    setup_cnt_d = 16'd0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    astb_d  = op_q[0];
                    dstb_d  = ~op_q[0];
                    state_d = ST_STROBE;
`ifdef EPP_HOST_TIMEOUT_EN
                    tmo_d   = 16'd0;
`endif
                end else begin
                    setup_cnt_d = setup_cnt_q + 16'd1;
                end
            end
            ST_STROBE: begin
                if (wait_s) begin
                    if (op_q[1]) begin
                        rd_d = EppDB;
                    end
                    astb_d  = 1'b1;
                    dstb_d  = 1'b1;
                    state_d = ST_RELEASE;
`ifdef EPP_HOST_TIMEOUT_EN
                    tmo_d   = 16'd0;
                end else if (tmo_q == TMO_LAST) begin
                    astb_d      = 1'b1;
                    dstb_d      = 1'b1;
                    wr_d        = 1'b1;
                    db_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
`endif
                end
            end
            ST_RELEASE: begin
                if (!wait_s) begin
                    wr_d        = 1'b1;
                    db_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = op_q[1] ? rd_q : 8'h00;
                    state_d     = ST_DONE;
`ifdef EPP_HOST_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    wr_d        = 1'b1;
                    db_oe_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_if.req_ready = (state_q == ST_IDLE);
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
    assign req_if.rsp_err   = rsp_err_q;
`else
    assign req_if.rsp_err   = 1'b0;
`endif

    assign EppAstb = astb_q;
    assign EppDstb = dstb_q;
    assign EppWR   = wr_q;
    assign EppDB   = db_oe_q ? data_q : 8'hzz;

endmodule

// File: tb/tb_epp_host.sv
// Scoreboard bench for epp_host against a register-file peripheral model and a
// reference model of expected responses.
module tb_epp_host;
    import epp_pkg::*;

    localparam int SETUP = 2;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       EppAstb, EppDstb, EppWR;
    logic       wait_r = 1'b0;
    wire  [7:0] EppDB;

    epp_host_if bus ();

    epp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_if  (bus),
        .EppAstb (EppAstb),
        .EppDstb (EppDstb),
        .EppWR   (EppWR),
        .EppWait (wait_r),
        .EppDB   (EppDB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Peripheral model: registers 0..15, start_blit at 12, start_fill at 13.
    int         mode = 0;     // 0 = responsive, 1 = never raises Wait
    int         dly  = 0;
    int         pcnt = 0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pregs [16];
    int         blit_cnt = 0;
    int         fill_cnt = 0;
    logic       model_oe;
    logic [7:0] model_dout;

    assign model_oe   = EppWR && wait_r && (!EppAstb || !EppDstb);
    assign model_dout = !EppAstb ? paddr : pregs[paddr[3:0]];
    assign EppDB      = model_oe ? model_dout : 8'hzz;

    always @(posedge clk) begin
        if (!EppAstb || !EppDstb) begin
            if (mode == 0 && !wait_r) begin
                if (pcnt >= dly) begin
                    wait_r <= 1'b1;
                    pcnt   <= 0;
                    if (!EppWR) begin
                        if (!EppAstb) paddr <= EppDB;
                        else begin
                            pregs[paddr[3:0]] <= EppDB;
                            if (paddr == 8'd12) blit_cnt <= blit_cnt + 1;
                            if (paddr == 8'd13) fill_cnt <= fill_cnt + 1;
                        end
                    end
                end else begin
                    pcnt <= pcnt + 1;
                end
            end
        end else begin
            wait_r <= 1'b0;
            pcnt   <= 0;
        end
    end

    // Reference model: what the peripheral should hold after each accepted command.
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_regs [16];
    logic [8:0] exp_q [$];
    int         accept_cyc = 0;

    int oe_viol   = 0;
    int both_viol = 0;
    always @(negedge clk) begin
        if (!rst && dut.db_oe_q && EppWR) oe_viol++;
        if (!EppAstb && !EppDstb) both_viol++;
    end

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {23'd0, bus.rsp_err, bus.rsp_data}, 32'h1ff);
            end else begin
                chk("rsp", {23'd0, bus.rsp_err, bus.rsp_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input op_t op, input logic [7:0] d, input bit push);
        int k;
        if (push) begin
            case (op)
                OP_AWR: begin exp_addr = d; exp_q.push_back(9'h000); end
                OP_DWR: begin exp_regs[exp_addr[3:0]] = d; exp_q.push_back(9'h000); end
                OP_ARD: exp_q.push_back({1'b0, exp_addr});
                default: exp_q.push_back({1'b0, exp_regs[exp_addr[3:0]]});
            endcase
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        k = 0;
        while (!bus.req_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_checks++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rdy_hi, nrsp;
        op_t op;
        logic [7:0] d;

        for (int i = 0; i < 16; i++) begin
            pregs[i]    = 8'h00;
            exp_regs[i] = 8'h00;
        end
        bus.req_valid = 1'b0;
        bus.req_op    = OP_AWR;
        bus.req_data  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_astb",  {31'd0, EppAstb}, 32'd1);
        chk("rst_dstb",  {31'd0, EppDstb}, 32'd1);
        chk("rst_wr",    {31'd0, EppWR}, 32'd1);
        chk("rst_oe",    {31'd0, dut.db_oe_q}, 32'd0);
        chk("rst_rspv",  {31'd0, bus.rsp_valid}, 32'd0);

        send(OP_AWR, 8'h0C, 1);
        send(OP_DWR, 8'h00, 1);
        wait_idle();
        chk("blit_once", blit_cnt, 32'd1);

        send(OP_AWR, 8'h00, 1);
        send(OP_DWR, 8'h34, 1);
        send(OP_AWR, 8'h01, 1);
        send(OP_DWR, 8'h12, 1);
        wait_idle();
        chk("x1", {16'd0, pregs[1], pregs[0]}, 32'h1234);

        send(OP_AWR, 8'h02, 1);
        send(OP_DWR, 8'hA5, 1);
        send(OP_DRD, 8'h5A, 1);
        send(OP_ARD, 8'h00, 1);
        wait_idle();

        dly = 0;
        send(OP_DWR, 8'h77, 1);
        lat = -1;
        rdy_hi = 0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            if (bus.rsp_valid) lat = cyc - accept_cyc;
            else if (bus.req_ready) rdy_hi++;
            if (lat < 0) @(negedge clk);
        end
        chk("latency", lat, 32'd10);
        chk("ready_low_busy", rdy_hi, 32'd0);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            op  = op_t'($urandom_range(0, 3));
            d   = (op == OP_AWR) ? 8'($urandom_range(0, 13)) : 8'($urandom);
            dly = $urandom_range(0, 3);
            send(op, d, 1);
        end
        wait_idle();
        dly = 0;
        chk("fill_count", fill_cnt, 32'(fill_cnt_expected()));

        mode = 1;
`ifdef EPP_HOST_TIMEOUT_EN
        send(OP_DRD, 8'h00, 0);
        exp_q.push_back(9'h100);
        lat = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            if (bus.rsp_valid) begin
                lat = cyc - accept_cyc;
                chk("tmo_strobe_high", {30'd0, EppAstb, EppDstb}, 32'd3);
            end
            if (lat < 0) @(negedge clk);
        end
        chk("tmo_latency", lat, 32'(SETUP + TMO));
        wait_idle();
        send(OP_DWR, 8'h99, 0);
        repeat (6) @(negedge clk);
`else
        send(OP_DWR, 8'h99, 0);
        nrsp = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        chk("no_rsp_stuck", nrsp, 32'd0);
`endif
        chk("dstb_low_before_rst", {31'd0, EppDstb}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_dstb",  {31'd0, EppDstb}, 32'd1);
        chk("mid_rst_wr",    {31'd0, EppWR}, 32'd1);
        chk("mid_rst_oe",    {31'd0, dut.db_oe_q}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_rst_rspv",  {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        repeat (4) @(negedge clk);

        send(OP_DRD, 8'h00, 1);
        wait_idle();

        chk("no_host_drive_on_read", oe_viol, 32'd0);
        chk("one_strobe_only", both_viol, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Expected start_fill count: derived from the reference register writes,
    // tracked by counting data writes issued while the reference address is 13.
    int fill_ref = 0;
    always @(posedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready && bus.req_op == OP_DWR && exp_addr == 8'd13)
            fill_ref <= fill_ref + 1;
    end

    function automatic int fill_cnt_expected();
        return fill_ref;
    endfunction

endmodule
